// File: rtl/mux_chan_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_chan_reg
// Purpose  : Registered N-channel multiplexer with per-channel valid/ready
//            handshake. It has two selection modes: addressed select, or
//            round-robin scan starting at a rotating pointer. A single output
//            register stage gives a latency of one cycle, and a word can be
//            consumed and replaced in the same cycle.
// Ports    : clk        - clock, rising edge
//            nRST       - asynchronous active-low reset
//            nCS        - active-low chip select (high blocks new transfers)
//            mode       - 0 = addressed select, 1 = round-robin scan
//            addr       - channel select in addressed mode
//            in_data    - CHANNELS x WIDTH packed inputs, ch k at [k*WIDTH +: WIDTH]
//            in_valid   - per-channel data valid
//            in_ready   - per-channel accept strobe (combinational)
//            Mout       - registered selected data (zero when empty)
//            out_valid  - Mout holds an unconsumed word
//            out_ready  - downstream accepts Mout
//            out_chan   - source channel of the word in Mout (zero when empty)
//            addr_err   - sticky out-of-range address flag
// Revision : 1.0 - initial release
// ============================================================================
module mux_chan_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic                      nCS,
    input  logic                      mode,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          Mout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_chan,
    output logic                      addr_err
);

    // Output register stage and rotating scan pointer
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [ADDR_W-1:0] chan_q,  chan_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;

    // Selection datapath
    logic              slot_free;
    logic              addr_ok;
    logic              rr_found;
    logic [ADDR_W-1:0] rr_grant;
    int                rr_best;
    int                rr_dist;
    logic [ADDR_W-1:0] sel;
    logic              sel_ok;
    logic              sel_valid;
    logic [WIDTH-1:0]  sel_data;
    logic              rdy_en;
    logic              transfer;

    // Round-robin arbiter. The winner is the valid channel closest to ptr
    // in the forward (wrapping) direction, so the grant is ptr itself when
    // that channel is valid.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_best  = CHANNELS;
        rr_dist  = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (k >= int'(ptr_q)) begin
                rr_dist = k - int'(ptr_q);
            end else begin
                rr_dist = k + CHANNELS - int'(ptr_q);
            end
            if (in_valid[k] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_found = 1'b1;
                rr_grant = ADDR_W'(k);
            end
        end
    end

    // Channel select, handshake and next-state logic
    always_comb begin
        slot_free = !valid_q || out_ready;
        addr_ok   = (int'(addr) < CHANNELS);

        if (mode) begin
            sel    = rr_grant;
            sel_ok = rr_found;
        end else begin
            // Addressed mode: readiness depends on addr only, never on in_valid
            sel    = addr;
            sel_ok = addr_ok;
        end

        // nRST gates readiness so no strobe is presented while in reset
        rdy_en = nRST && !nCS && slot_free && sel_ok;

        in_ready  = '0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == ADDR_W'(k)) begin
                in_ready[k] = rdy_en;
                sel_valid   = in_valid[k];
                sel_data    = in_data[k*WIDTH +: WIDTH];
            end
        end

        transfer = rdy_en && sel_valid;

        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        err_d   = err_q;

        if (transfer) begin
            data_d  = sel_data;
            chan_d  = sel;
            valid_d = 1'b1;
        end else if (out_ready) begin
            // Word consumed with nothing replacing it: clear so an empty
            // register always presents zero data and channel.
            data_d  = '0;
            chan_d  = '0;
            valid_d = 1'b0;
        end

        if (transfer && mode) begin
            if (int'(sel) == CHANNELS - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = sel + ADDR_W'(1);
            end
        end

        if (!mode && !nCS && !addr_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign Mout      = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
    assign addr_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_chan_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_chan_reg
// Purpose  : Self-checking bench for mux_chan_reg (6 channels, so that
//            addresses 6 and 7 are out of range). A reference model predicts
//            the handshake and pushes expected words into a queue. A separate
//            monitor compares each presented word against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_chan_reg;

    localparam int W  = 8;
    localparam int CH = 6;
    localparam int AW = 3;

    logic              clk = 1'b0;
    logic              nRST = 1'b0;
    logic              nCS = 1'b1;
    logic              mode = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [CH*W-1:0]   in_data = '0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH-1:0]     in_ready;
    logic [W-1:0]      Mout;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [AW-1:0]     out_chan;
    logic              addr_err;

    mux_chan_reg #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .nCS       (nCS),
        .mode      (mode),
        .addr      (addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Mout      (Mout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int           c;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit   ref_valid = 1'b0;
    bit   ref_err   = 1'b0;
    int   ref_ptr   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Inputs change on the falling edge; the
    // model predicts readiness and any transfer, and commits its state at
    // the following rising edge. pch >= 0 forces channel pch to pval.
    task automatic step(input bit rst_n_i, input bit cs_i, input bit md_i, input int a_i,
                        input logic [CH-1:0] v_i, input bit ordy_i,
                        input int pch, input int pval);
        logic [CH-1:0] rdy;
        bit            xfer;
        bit            slot;
        int            g;
        int            k;
        @(negedge clk);
        nRST      = rst_n_i;
        nCS       = cs_i;
        mode      = md_i;
        addr      = AW'(a_i);
        in_valid  = v_i;
        out_ready = ordy_i;
        for (int c = 0; c < CH; c++) in_data[c*W +: W] = W'($urandom);
        if (pch >= 0) in_data[pch*W +: W] = W'(pval);
        #1;
        if (!rst_n_i) begin
            ref_valid = 1'b0;
            ref_err   = 1'b0;
            ref_ptr   = 0;
            q.delete();
        end
        slot = !ref_valid || ordy_i;
        rdy  = '0;
        xfer = 1'b0;
        g    = -1;
        if (rst_n_i && !cs_i) begin
            if (!md_i) begin
                if (a_i < CH && slot) begin
                    rdy[a_i] = 1'b1;
                    xfer     = v_i[a_i];
                    g        = a_i;
                end
            end else begin
                for (int i = 0; i < CH; i++) begin
                    k = (ref_ptr + i) % CH;
                    if (g < 0 && v_i[k]) g = k;
                end
                if (g >= 0 && slot) begin
                    rdy[g] = 1'b1;
                    xfer   = 1'b1;
                end
            end
        end
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(ref_valid));
        check("addr_err", 64'(addr_err), 64'(ref_err));
        if (xfer) q.push_back('{in_data[g*W +: W], g});
        @(posedge clk);
        if (rst_n_i) begin
            if (!cs_i && !md_i && a_i >= CH) ref_err = 1'b1;
            if (xfer) begin
                ref_valid = 1'b1;
                if (md_i) ref_ptr = (g + 1) % CH;
            end else if (ordy_i) begin
                ref_valid = 1'b0;
            end
        end
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h expected=none at %0t", Mout, $time);
                end else begin
                    check("Mout", 64'(Mout), 64'(q[0].d));
                    check("out_chan", 64'(out_chan), 64'(q[0].c));
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                check("Mout_empty", 64'(Mout), 64'd0);
                check("out_chan_empty", 64'(out_chan), 64'd0);
            end
        end
    end

    initial begin
        // Reset state
        step(0, 0, 0, 5, '1, 1, -1, 0);
        step(0, 0, 1, 0, '1, 1, -1, 0);
        step(1, 1, 0, 0, '0, 1, -1, 0);

        // Addressed select: ch5 = 0xA5
        step(1, 0, 0, 5, 6'b100000, 1, 5, 8'hA5);
        step(1, 1, 0, 0, '0, 1, -1, 0);

        // Round-robin fairness: all valid, expect 0..5,0 with no gaps
        for (int i = 0; i < CH + 1; i++) step(1, 0, 1, 0, '1, 1, -1, 0);
        step(1, 1, 1, 0, '0, 1, -1, 0);

        // Backpressure: load 0x3C on ch1, hold 4 cycles, then replace from ch2
        step(1, 0, 0, 1, 6'b000010, 0, 1, 8'h3C);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 2, '1, 0, -1, 0);
        step(1, 0, 0, 2, 6'b000100, 1, -1, 0);

        // Chip select high while a word is held: it still drains
        step(1, 1, 0, 2, '1, 1, -1, 0);
        step(1, 1, 0, 2, '1, 1, -1, 0);

        // Mode change keeps held word; empty round-robin holds ptr
        step(1, 0, 0, 4, '1, 0, -1, 0);
        step(1, 0, 1, 0, '1, 0, -1, 0);
        step(1, 0, 1, 0, '0, 1, -1, 0);
        step(1, 0, 1, 0, 6'b010001, 1, -1, 0);

        // Bad address: 7 and 6 are out of range, flag is sticky
        step(1, 0, 0, 7, '1, 1, -1, 0);
        step(1, 0, 0, 6, '1, 1, -1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, i, '1, 1, -1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1, ($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
                 CH'($urandom), ($urandom_range(0, 3) != 0), -1, 0);
        end

        // Async reset with a held word and ptr = 4
        step(1, 0, 1, 0, 6'b001000, 1, -1, 0);
        step(1, 0, 1, 0, '0, 0, -1, 0);
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_Mout", 64'(Mout), 64'd0);
        check("async_out_chan", 64'(out_chan), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd0);
        ref_valid = 1'b0;
        ref_err   = 1'b0;
        ref_ptr   = 0;
        q.delete();
        step(0, 0, 1, 0, '1, 1, -1, 0);
        // After release, grants restart at ch0
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, '1, 1, -1, 0);

        // Drain
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, '0, 1, -1, 0);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_chan_reg.md
MUX_CHAN_REG -- requirements
Module: mux_chan_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width of every channel and of Mout.
REQ-002 Parameter CHANNELS, default 8: number of input channels, legal range 2..256.
REQ-003 Parameter ADDR_W, default 3: width of addr and out_chan, SHALL satisfy 2**ADDR_W >= CHANNELS.
REQ-004 Ports, in order:
- clk  input  1  single clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- nCS  input  1  active-low chip select; high blocks new transfers.
- mode  input  1  0 = addressed select, 1 = round-robin scan.
- addr  input  ADDR_W  channel select in addressed mode.
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept strobe.
- Mout  output  WIDTH  registered selected data.
- out_valid  output  1  Mout holds an unconsumed word.
- out_ready  input  1  downstream accepts Mout.
- out_chan  output  ADDR_W  source channel of the word in Mout.
- addr_err  output  1  sticky flag: addressed mode used addr >= CHANNELS.

Function
REQ-005 Single output register stage: data accepted on edge N appears on Mout with out_valid high after edge N; latency 1 cycle.
REQ-006 slot_free = !out_valid || out_ready, combinational.
REQ-007 Transfer into the register occurs when nCS = 0, slot_free = 1 and the selected channel has in_valid = 1.
REQ-008 Addressed mode: selected channel = addr; in_ready[addr] = nCS==0 && slot_free && addr < CHANNELS; all other in_ready bits 0.
REQ-009 Round-robin mode: selected channel = first k with in_valid[k] = 1, scanning ptr, ptr+1, ... modulo CHANNELS; only that bit of in_ready may be high.
REQ-010 ptr SHALL advance to (granted + 1) mod CHANNELS on each round-robin transfer and hold otherwise; ptr wraps from CHANNELS-1 to 0.
REQ-011 Addressed-mode transfers SHALL NOT modify ptr.
REQ-012 in_ready SHALL be combinational and never depend on in_valid of the same channel in addressed mode.
REQ-013 When out_valid = 1 and out_ready = 0, Mout, out_chan and out_valid SHALL hold.
REQ-014 When out_ready = 1 and no new transfer occurs, out_valid SHALL drop to 0 on the next edge.
REQ-015 When out_valid = 0, Mout SHALL be driven all-zero and out_chan 0.
REQ-016 Simultaneous consume and accept (out_valid = 1, out_ready = 1, transfer) SHALL replace the word with no bubble cycle.
REQ-017 nCS = 1 SHALL force all in_ready low but SHALL NOT discard a held word; downstream may still drain it.
REQ-018 Addressed mode with nCS = 0 and addr >= CHANNELS SHALL set addr_err on the next edge; addr_err clears only on reset.
REQ-019 A mode change takes effect on the same cycle; a held word is unaffected.
REQ-020 No valid channel in round-robin mode: no transfer, all in_ready low, ptr holds.

Reset
REQ-021 nRST low SHALL asynchronously clear out_valid, Mout, out_chan, addr_err and ptr to 0, regardless of clk.
REQ-022 Reset mid-transfer SHALL drop any held word; all in_ready SHALL be low while nRST = 0.
REQ-023 Release of nRST SHALL be honoured on the first rising edge after deassertion.

Verification
REQ-024 Addressed: WIDTH=8, CHANNELS=8, mode=0, addr=5, in_data ch5=0xA5, in_valid=0x20, out_ready=1 -> in_ready=0x20; next cycle Mout=0xA5, out_chan=5, out_valid=1.
REQ-025 Round-robin fairness: all in_valid=0xFF, out_ready=1, mode=1 -> out_chan sequence 0,1,...,7,0 on consecutive cycles with no gaps.
REQ-026 Backpressure: word 0x3C held with out_ready=0 for 4 cycles -> Mout stays 0x3C, all in_ready=0; out_ready=1 with ch2 valid -> next word loads with no bubble.
REQ-027 Chip select: nCS=1 while word held, out_ready=1 -> word drains, out_valid=0, Mout=0; no in_ready asserted.
REQ-028 Bad address: CHANNELS=6, mode=0, addr=7, nCS=0 -> in_ready=0, addr_err=1 next cycle and sticky until nRST.
REQ-029 Async reset: assert nRST mid-cycle with out_valid=1, ptr=4 -> out_valid, Mout, ptr = 0 immediately without a clock edge; after release, round-robin grants start at ch0.
